uart_rx_param: RTL

//  Parametrised RS-232 UART receiver: configurable data width, parity mode, stop bits, baud divisor.

---
 rtl/uart_rx_param.sv | 136 +++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchronises the serial line, samples each bit at mid-bit,
// checks parity and stop bits, and offers each word downstream through a one-entry holding register.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 RXD_i,
  input  logic                 ready_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] MID_LAST  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t                 state, state_nxt;
  logic                   rx_meta, rx_s;
  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       idx;
  logic [DATA_BITS-1:0]   shift_r;
  logic                   par_err_r, frm_err_r, complete;
  logic                   bit_tick, frame_done;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RXD_i;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (!rx_s) state_nxt = START;
      START: if (cnt == MID_LAST) state_nxt = rx_s ? IDLE : DATA;
      DATA:  if (bit_tick && idx == DATA_LAST) state_nxt = (PARITY != 0) ? PAR : STOP;
      PAR:   if (bit_tick) state_nxt = STOP;
      STOP:  if (bit_tick && idx == STOP_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_o     = (state != IDLE);
    bit_tick   = (cnt == BIT_LAST) && (state == DATA || state == PAR || state == STOP);
    frame_done = (state == STOP) && bit_tick && (idx == STOP_LAST);
  end

  // Bit timing, shift register and per-frame error accumulation.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt       <= '0;
      idx       <= '0;
      shift_r   <= '0;
      par_err_r <= 1'b0;
      frm_err_r <= 1'b0;
      complete  <= 1'b0;
    end else begin
      complete <= frame_done;
      case (state)
        IDLE: begin
          cnt <= '0;
          idx <= '0;
        end
        START: begin
          cnt       <= (cnt == MID_LAST) ? '0 : cnt + CNT_W'(1);
          par_err_r <= 1'b0;
          frm_err_r <= 1'b0;
        end
        default: begin
          cnt <= bit_tick ? '0 : cnt + CNT_W'(1);
          if (bit_tick) begin
            if (state == DATA) begin
              shift_r <= {rx_s, shift_r[DATA_BITS-1:1]};
              idx     <= (idx == DATA_LAST) ? '0 : idx + IDX_W'(1);
            end else if (state == PAR) begin
              par_err_r <= ((^shift_r) ^ rx_s) != (PARITY == 1);
            end else begin
              idx <= idx + IDX_W'(1);
              if (!rx_s) frm_err_r <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Holding register: a completed frame is dropped (overrun) only if the previous word is still unaccepted.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data_o       <= '0;
      valid_o      <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (complete) begin
        if (!valid_o || ready_i) begin
          data_o       <= shift_r;
          parity_err_o <= par_err_r;
          frame_err_o  <= frm_err_r;
          valid_o      <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule
